// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the async FIFO: read pointer, 2-FF Gray write-pointer synchroniser,
// registered EMPTY/RD_LEVEL. Optional ALMOST_EMPTY flag built only with FIFO_ALMOST_EMPTY_EN.
module fifo_read_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int AE_THRESH  = 2
) (
  input  logic                  R_CLK,
  input  logic                  R_RST,
  input  logic                  RD_INC,
  input  logic [ADDR_WIDTH:0]   WR_PTR_GRAY,
  output logic [ADDR_WIDTH-1:0] R_addr,
  output logic [ADDR_WIDTH:0]   RD_PTR_GRAY,
  output logic                  EMPTY,
  output logic                  RD_ACCEPT,
  output logic [ADDR_WIDTH:0]   RD_LEVEL,
  output logic                  ALMOST_EMPTY
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  if (FIFO_DEPTH != (1 << ADDR_WIDTH) || AE_THRESH < 0 || AE_THRESH > FIFO_DEPTH) begin : g_bad_cfg
    $error("fifo_read_ctrl: FIFO_DEPTH must equal 2**ADDR_WIDTH and AE_THRESH lie in 0..FIFO_DEPTH");
  end

  logic [ADDR_WIDTH:0] rd_bin;
  logic [ADDR_WIDTH:0] rd_bin_next;
  logic [ADDR_WIDTH:0] gray_next;
  logic [ADDR_WIDTH:0] wq1;
  logic [ADDR_WIDTH:0] wq2;
  logic [ADDR_WIDTH:0] wq2_bin;
  logic [ADDR_WIDTH:0] level_next;
  logic                pop;

  always_comb begin
    pop         = RD_INC & ~EMPTY;
    rd_bin_next = rd_bin + {{ADDR_WIDTH{1'b0}}, pop};
    gray_next   = rd_bin_next ^ (rd_bin_next >> 1);
    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    wq2_bin = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      wq2_bin[i] = ^(wq2 >> i);
    end
    level_next = wq2_bin - rd_bin_next;
  end

  assign R_addr = rd_bin[ADDR_WIDTH-1:0];

  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      rd_bin      <= '0;
      RD_PTR_GRAY <= '0;
      wq1         <= '0;
      wq2         <= '0;
      EMPTY       <= 1'b1;
      RD_ACCEPT   <= 1'b0;
      RD_LEVEL    <= '0;
    end else begin
      rd_bin      <= rd_bin_next;
      RD_PTR_GRAY <= gray_next;
      wq1         <= WR_PTR_GRAY;
      wq2         <= wq1;
      // Compared against the already-synchronised wq2, so a write racing the last pop
      // can only delay non-empty, never fake it.
      EMPTY       <= (gray_next == wq2);
      RD_ACCEPT   <= pop;
      RD_LEVEL    <= level_next;
    end
  end

`ifdef FIFO_ALMOST_EMPTY_EN
  localparam logic [ADDR_WIDTH:0] AE_LVL = AE_THRESH[ADDR_WIDTH:0];

  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      ALMOST_EMPTY <= 1'b1;
    end else begin
      ALMOST_EMPTY <= (level_next <= AE_LVL);
    end
  end
`else
  assign ALMOST_EMPTY = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Scoreboard bench for fifo_read_ctrl: a count-based reference model predicts each cycle's
// outputs into a queue; a negedge monitor pops and compares, and pairs RD_ACCEPT with pops.
module tb_fifo_read_ctrl;

  logic       R_CLK;
  logic       R_RST;
  logic       RD_INC;
  logic [3:0] WR_PTR_GRAY;
  logic [2:0] R_addr;
  logic [3:0] RD_PTR_GRAY;
  logic       EMPTY;
  logic       RD_ACCEPT;
  logic [3:0] RD_LEVEL;
  logic       ALMOST_EMPTY;

`ifdef FIFO_ALMOST_EMPTY_EN
  localparam bit AE_EN = 1'b1;
`else
  localparam bit AE_EN = 1'b0;
`endif

  fifo_read_ctrl #(.ADDR_WIDTH(3), .FIFO_DEPTH(8), .AE_THRESH(2)) dut (
    .R_CLK        (R_CLK),
    .R_RST        (R_RST),
    .RD_INC       (RD_INC),
    .WR_PTR_GRAY  (WR_PTR_GRAY),
    .R_addr       (R_addr),
    .RD_PTR_GRAY  (RD_PTR_GRAY),
    .EMPTY        (EMPTY),
    .RD_ACCEPT    (RD_ACCEPT),
    .RD_LEVEL     (RD_LEVEL),
    .ALMOST_EMPTY (ALMOST_EMPTY)
  );

  typedef struct packed {
    logic       empty;
    logic       acc;
    logic       ae;
    logic [3:0] lvl;
    logic [3:0] gray;
    logic [2:0] addr;
  } exp_t;

  exp_t       cyc_q[$];
  logic [3:0] acc_q[$];
  int         total = 0;
  int         bad   = 0;

  // Reference model: plain counts of writes/reads; the read domain sees the write count
  // that was driven two clock edges earlier.
  int   hist[2];
  int   m_rd;
  int   rd_total;
  int   wr_total;
  bit   m_empty;
  exp_t pend;

  initial begin
    R_CLK = 1'b0;
    forever #5 R_CLK = ~R_CLK;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [3:0] to_gray(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e.empty = 1'b1;
    e.acc   = 1'b0;
    e.ae    = AE_EN;
    e.lvl   = '0;
    e.gray  = '0;
    e.addr  = '0;
    return e;
  endfunction

  function void model_reset();
    hist     = '{0, 0};
    m_rd     = 0;
    rd_total = 0;
    wr_total = 0;
    m_empty  = 1'b1;
  endfunction

  function exp_t model_step(input bit rd);
    exp_t e;
    int   seen;
    int   lvl;
    seen  = hist[0];
    e.acc = rd && !m_empty;
    if (e.acc) begin
      rd_total++;
      m_rd = (m_rd + 1) % 16;
    end
    lvl     = (seen - m_rd + 16) % 16;
    m_empty = (lvl == 0);
    hist[0] = hist[1];
    hist[1] = wr_total % 16;
    e.empty = m_empty;
    e.lvl   = 4'(lvl);
    e.ae    = AE_EN && (lvl <= 2);
    e.gray  = to_gray(m_rd);
    e.addr  = 3'(m_rd % 8);
    return e;
  endfunction

  task automatic push(input exp_t e);
    cyc_q.push_back(e);
    if (e.acc) acc_q.push_back(e.gray);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
    end
  endtask

  // One normal cycle: release reset, queue the expectation for the previous edge, drive new inputs.
  task automatic slot(input bit rd, input bit wr_inc);
    R_RST = 1'b1;
    push(pend);
    if (wr_inc && (wr_total - rd_total) < 8) wr_total++;
    WR_PTR_GRAY = to_gray(wr_total);
    RD_INC      = rd;
    pend        = model_step(rd);
    @(posedge R_CLK);
    #1;
  endtask

  // Reset asserted mid-cycle: reset values are expected at the following negedge, before any edge.
  task automatic rst_slot(input bit rd);
    R_RST = 1'b0;
    model_reset();
    WR_PTR_GRAY = '0;
    RD_INC      = rd;
    pend        = reset_exp();
    push(pend);
    @(posedge R_CLK);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge R_CLK);
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        chk("empty",        8'(EMPTY),        8'(e.empty));
        chk("rd_accept",    8'(RD_ACCEPT),    8'(e.acc));
        chk("rd_level",     8'(RD_LEVEL),     8'(e.lvl));
        chk("rd_ptr_gray",  8'(RD_PTR_GRAY),  8'(e.gray));
        chk("r_addr",       8'(R_addr),       8'(e.addr));
        chk("almost_empty", 8'(ALMOST_EMPTY), 8'(e.ae));
      end
      if (RD_ACCEPT === 1'b1) begin
        if (acc_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL accept_unexpected at %0t: got pulse expected none", $time);
        end else begin
          chk("accept_ptr", 8'(RD_PTR_GRAY), 8'(acc_q.pop_front()));
        end
      end
    end
  end

  initial begin : stimulus
    R_RST       = 1'b0;
    RD_INC      = 1'b0;
    WR_PTR_GRAY = '0;
    model_reset();
    pend = reset_exp();
    @(posedge R_CLK);
    #1;

    repeat (3) rst_slot(1'b1);

    // One write, no reads: EMPTY/RD_LEVEL change only at the third edge.
    slot(1'b0, 1'b1);
    repeat (4) slot(1'b0, 1'b0);

    // Pop to empty with surplus requests.
    repeat (3) slot(1'b1, 1'b0);
    repeat (2) slot(1'b0, 1'b0);

    // Full FIFO (write pointer jumps to 8), drain with one extra pop, then wrap traffic.
    rst_slot(1'b0);
    wr_total = 8;
    repeat (3) slot(1'b0, 1'b0);
    repeat (9) slot(1'b1, 1'b0);
    repeat (2) slot(1'b0, 1'b0);
    repeat (8) begin
      slot(1'b0, 1'b1);
      slot(1'b0, 1'b0);
      slot(1'b0, 1'b0);
      slot(1'b1, 1'b0);
    end
    repeat (2) slot(1'b0, 1'b0);

    // Reset mid-drain with a pop in flight; afterwards reads must be ignored.
    repeat (5) slot(1'b0, 1'b1);
    repeat (3) slot(1'b0, 1'b0);
    slot(1'b1, 1'b0);
    rst_slot(1'b1);
    repeat (4) slot(1'b1, 1'b0);

    // Almost-empty sweep: drain from level 4.
    repeat (4) slot(1'b0, 1'b1);
    repeat (3) slot(1'b0, 1'b0);
    repeat (5) slot(1'b1, 1'b0);

    repeat (800) begin
      if ($urandom_range(0, 99) == 0) rst_slot(1'($urandom_range(0, 1)));
      else slot(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (2) slot(1'b0, 1'b0);

    @(negedge R_CLK);
    #1;
    chk("cyc_queue_drained", 8'(cyc_q.size()), 8'd0);
    chk("acc_queue_drained", 8'(acc_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
